// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Holds the FSM state encoding, PC mux selects and the reset/increment defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INC   = 32'd4;

    // Redirect targets are always word aligned once they reach the PC.
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bundle of the fetch controller's hazard, redirect, memory and decode-side signals.
// The controller uses the master modport; the surrounding pipeline/memory uses slave.
interface fetch_controller_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, mem_ack, mem_data,
        output mem_req, mem_addr, instruction, pc_plus4, instr_valid
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, mem_ack, mem_data,
        input  mem_req, mem_addr, instruction, pc_plus4, instr_valid
    );

endinterface

// File: rtl/pc_register.sv
// Program counter with its next-PC mux: hold, sequential increment or aligned redirect.
// Arithmetic wraps modulo 2^32.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     sel_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        // NOTE: default assignment first so every path drives pc_d and no latch is inferred.
        pc_d = pc_q;
        case (sel_i)
            PC_SEQ:      pc_d = pc_q + PC_INC;
            PC_REDIRECT: pc_d = align_target(target_i);
            default:     pc_d = pc_q;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch FSM (IDLE/FETCH/VALID) with registered decode outputs and a
// pending-redirect register for redirects that arrive while a request is outstanding.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master fc_if
);

    fetch_state_e state_q;
    logic         mem_req_q;
    logic         instr_valid_q;
    logic [31:0]  instruction_q;
    logic [31:0]  pc_plus4_q;
    logic         pend_valid_q;
    logic [31:0]  pend_target_q;

    logic [31:0]  pc;
    pc_sel_e      pc_sel;
    logic [31:0]  pc_target;

    logic         redirect_req;
    logic [31:0]  redirect_tgt;
    logic         pend_any;
    logic [31:0]  pend_tgt;

    assign redirect_req = fc_if.jump | fc_if.branch_taken;
    assign redirect_tgt = fc_if.jump ? fc_if.jump_target : fc_if.branch_target;

    // A redirect arriving in the same cycle as the ack supersedes any older pending one.
    assign pend_any = redirect_req | pend_valid_q;
    assign pend_tgt = redirect_req ? redirect_tgt : pend_target_q;

    always_comb begin
        pc_sel    = PC_HOLD;
        pc_target = redirect_tgt;
        case (state_q)
            ST_FETCH: begin
                if (fc_if.mem_ack && pend_any) begin
                    pc_sel    = PC_REDIRECT;
                    pc_target = pend_tgt;
                end
            end
            ST_VALID: begin
                if (redirect_req) begin
                    pc_sel = PC_REDIRECT;
                end else if (!fc_if.stall) begin
                    pc_sel = PC_SEQ;
                end
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_register (
        .clk      (clk),
        .rst      (rst),
        .sel_i    (pc_sel),
        .target_i (pc_target),
        .pc_o     (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instruction_q <= 32'h0;
            pc_plus4_q    <= 32'h0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_FETCH;
                    mem_req_q <= 1'b1;
                    if (redirect_req) begin
                        pend_valid_q  <= 1'b1;
                        pend_target_q <= redirect_tgt;
                    end
                end
                ST_FETCH: begin
                    if (fc_if.mem_ack) begin
                        if (pend_any) begin
                            // Stale word is dropped; re-request at the redirect target.
                            pend_valid_q <= 1'b0;
                        end else begin
                            instruction_q <= fc_if.mem_data;
                            pc_plus4_q    <= pc + PC_INC;
                            instr_valid_q <= 1'b1;
                            mem_req_q     <= 1'b0;
                            state_q       <= ST_VALID;
                        end
                    end else if (redirect_req) begin
                        pend_valid_q  <= 1'b1;
                        pend_target_q <= redirect_tgt;
                    end
                end
                ST_VALID: begin
                    if (redirect_req || !fc_if.stall) begin
                        instr_valid_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        state_q       <= ST_FETCH;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fc_if.mem_req     = mem_req_q;
    assign fc_if.mem_addr    = pc;
    assign fc_if.instruction = instruction_q;
    assign fc_if.pc_plus4    = pc_plus4_q;
    assign fc_if.instr_valid = instr_valid_q;

endmodule
